simple_router: RTL and testbench

Request-side counterpart of the slave read-data multiplexer in the bus fabric. Takes one master request and decodes its address against per-slave base/mask windows. Forwards the request to exactly one slave and holds the one-hot `sel` that steers the read-data mux until the slave acknowledges. Unmapped addresses get an error response; an optional timeout does the same for slaves that never acknowledge.

---
 rtl/simple_router.sv | 141 ++++++++++++++
 tb/tb_simple_router.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_router.sv
// simple_router
//   Request-side half of the bus fabric. Decodes one master request against
//   per-slave base/mask windows and forwards it to exactly one slave. The
//   one-hot sel drives the read-data mux until that slave acknowledges.
//   Addresses that hit no window are answered with an error response.
//
// Optional feature (macro SIMPLE_ROUTER_TIMEOUT_EN):
//   When defined, a slave that has not acknowledged after TIMEOUT_C cycles in
//   WAIT_ACK is abandoned and the master gets an error response instead.
//   When undefined, WAIT_ACK waits indefinitely and TIMEOUT_C is ignored.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   m_req, m_we        master request (held until m_ack) and write enable
//   m_addr, m_wd       master address and write data
//   m_ack, m_err       completion pulse and its error qualifier
//   s_req              per-slave request, one-hot or zero
//   s_we, s_addr, s_wd latched request fields broadcast to all slaves
//   s_ack              per-slave acknowledge
//   sel                one-hot read-data mux select, zero when idle
module simple_router #(
    parameter int                      slv_c     = 4,
    parameter logic [slv_c-1:0][31:0]  SLV_BASE  = {32'h0003_0000, 32'h0002_0000,
                                                    32'h0001_0000, 32'h0000_0000},
    parameter logic [slv_c-1:0][31:0]  SLV_MASK  = {4{32'hFFFF_0000}},
    parameter int                      TIMEOUT_C = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [31:0]       m_addr,
    input  logic [31:0]       m_wd,
    output logic              m_ack,
    output logic              m_err,
    output logic [slv_c-1:0]  s_req,
    output logic              s_we,
    output logic [31:0]       s_addr,
    output logic [31:0]       s_wd,
    input  logic [slv_c-1:0]  s_ack,
    output logic [slv_c-1:0]  sel
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        ERR
    } state_t;

    state_t            state;
    logic [slv_c-1:0]  winner;
    logic              hit_any;
    logic              sel_ack;

`ifdef SIMPLE_ROUTER_TIMEOUT_EN
    // The counter only has to reach TIMEOUT_C-1: the cycle that sees that
    // value is the last of TIMEOUT_C cycles spent waiting.
    localparam int              cnt_w  = (TIMEOUT_C > 1) ? $clog2(TIMEOUT_C) : 1;
    localparam logic [cnt_w-1:0] t_last = cnt_w'(TIMEOUT_C - 1);
    logic [cnt_w-1:0]           tcount;
`endif

    // Scan from the highest index down so the lowest hitting window is the
    // last one written and therefore wins when windows overlap.
    always_comb begin
        winner  = '0;
        hit_any = 1'b0;
        for (int i = slv_c - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[i]) == SLV_BASE[i]) begin
                winner    = '0;
                winner[i] = 1'b1;
                hit_any   = 1'b1;
            end
        end
    end

    // sel is non-zero only in WAIT_ACK, so masking s_ack with it both ignores
    // non-selected slaves and keeps m_ack low in IDLE. The ack path stays
    // combinational so read data crosses the mux in the same cycle.
    assign sel_ack = |(s_ack & sel);
    assign m_ack   = (state == ERR) || sel_ack;
    assign m_err   = (state == ERR);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            s_req  <= '0;
            sel    <= '0;
            s_we   <= 1'b0;
            s_addr <= '0;
            s_wd   <= '0;
`ifdef SIMPLE_ROUTER_TIMEOUT_EN
            tcount <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m_req) begin
                        if (hit_any) begin
                            s_we   <= m_we;
                            s_addr <= m_addr;
                            s_wd   <= m_wd;
                            sel    <= winner;
                            s_req  <= winner;
                            state  <= WAIT_ACK;
`ifdef SIMPLE_ROUTER_TIMEOUT_EN
                            tcount <= '0;
`endif
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                WAIT_ACK: begin
                    // An ack in the limit cycle is checked first, so it wins.
                    if (sel_ack) begin
                        s_req <= '0;
                        sel   <= '0;
                        state <= IDLE;
                    end
`ifdef SIMPLE_ROUTER_TIMEOUT_EN
                    else if (tcount == t_last) begin
                        s_req <= '0;
                        sel   <= '0;
                        state <= ERR;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
`endif
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_router.sv
// tb_simple_router
//   Self-checking bench for simple_router. Completed transactions on the main
//   instance are predicted into a scoreboard queue when the master request is
//   driven and popped by a monitor whenever m_ack is seen. A second instance
//   with overlapping windows covers lowest-index priority.
module tb_simple_router;

    logic        clk = 1'b0;
    logic        resetn;

    // Main instance, default windows, short timeout.
    logic        m_req, m_we, m_ack, m_err, s_we;
    logic [31:0] m_addr, m_wd, s_addr, s_wd;
    logic [3:0]  s_req, s_ack, sel;
    logic [3:0]  autoAck, manAck;

    // Second instance, windows 1 and 3 overlap.
    logic        o_req, o_we, o_ack, o_err, o_swe;
    logic [31:0] o_addr, o_wd, o_saddr, o_swd;
    logic [3:0]  o_sreq, o_sack, o_sel;

    int checks = 0;
    int errors = 0;
    int ackCount = 0;

    typedef struct {
        logic [3:0]  sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
    } exp_t;

    exp_t sbq[$];

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Slaves listed in autoAck answer in their first WAIT_ACK cycle; manAck
    // lets the stimulus raise an acknowledge at an exact cycle.
    assign s_ack = (s_req & autoAck) | manAck;

    simple_router #(
        .slv_c     (4),
        .TIMEOUT_C (8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .m_req  (m_req),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wd   (m_wd),
        .m_ack  (m_ack),
        .m_err  (m_err),
        .s_req  (s_req),
        .s_we   (s_we),
        .s_addr (s_addr),
        .s_wd   (s_wd),
        .s_ack  (s_ack),
        .sel    (sel)
    );

    simple_router #(
        .slv_c    (4),
        .SLV_BASE ({32'h0001_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000})
    ) dutOvl (
        .clk    (clk),
        .resetn (resetn),
        .m_req  (o_req),
        .m_we   (o_we),
        .m_addr (o_addr),
        .m_wd   (o_wd),
        .m_ack  (o_ack),
        .m_err  (o_err),
        .s_req  (o_sreq),
        .s_we   (o_swe),
        .s_addr (o_saddr),
        .s_wd   (o_swd),
        .s_ack  (o_sack),
        .sel    (o_sel)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one master request at the current time and, when the request is
    // expected to complete, record what the completion must look like.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [3:0] expSel, input logic expErr, input bit expectAck);
        exp_t e;
        m_req  = 1'b1;
        m_we   = we;
        m_addr = addr;
        m_wd   = wd;
        if (expectAck) begin
            e.sel  = expSel;
            e.we   = we;
            e.addr = addr;
            e.wd   = wd;
            e.err  = expErr;
            sbq.push_back(e);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: on the falling edge, every m_ack must match the oldest
    // prediction; an error pulse must carry sel and s_req at zero.
    always @(negedge clk) begin
        exp_t e;
        if (resetn === 1'b1 && m_ack === 1'b1) begin
            ackCount++;
            if (sbq.size() == 0) begin
                checkOutput("unexpected_ack", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("ack_err", m_err, e.err);
                checkOutput("ack_sel", sel, e.sel);
                checkOutput("ack_sreq", s_req, e.sel);
                if (!e.err) begin
                    checkOutput("ack_addr", s_addr, e.addr);
                    checkOutput("ack_we", s_we, e.we);
                    if (e.we) checkOutput("ack_wd", s_wd, e.wd);
                end
            end
        end
        if (resetn === 1'b1 && m_err === 1'b1 && m_ack !== 1'b1) begin
            checkOutput("err_without_ack", m_ack, 1'b1);
        end
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Main stimulus sequence.
    initial begin
        resetn  = 1'b0;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wd    = '0;
        autoAck = '0;
        manAck  = '0;
        o_req   = 1'b0;
        o_we    = 1'b0;
        o_addr  = '0;
        o_wd    = '0;
        o_sack  = '0;

        // Reset values.
        #3;
        checkOutput("rst_sreq", s_req, 4'b0000);
        checkOutput("rst_sel", sel, 4'b0000);
        checkOutput("rst_ack", m_ack, 1'b0);
        checkOutput("rst_err", m_err, 1'b0);
        checkOutput("rst_swe", s_we, 1'b0);
        checkOutput("rst_saddr", s_addr, 32'h0);
        checkOutput("rst_swd", s_wd, 32'h0);
        step();
        step();
        resetn = 1'b1;
        step();

        // Write to slave 2, ack three cycles after s_req rises.
        applyStimulus(1'b1, 32'h0002_0010, 32'hDEAD_BEEF, 4'b0100, 1'b0, 1'b1);
        step();
        checkOutput("w_sreq", s_req, 4'b0100);
        checkOutput("w_sel", sel, 4'b0100);
        checkOutput("w_saddr", s_addr, 32'h0002_0010);
        checkOutput("w_swd", s_wd, 32'hDEAD_BEEF);
        checkOutput("w_swe", s_we, 1'b1);
        checkOutput("w_noack", m_ack, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("w_hold_sreq", s_req, 4'b0100);
            checkOutput("w_hold_ack", m_ack, 1'b0);
        end
        step();
        manAck = 4'b0100;
        #1;
        checkOutput("w_ack", m_ack, 1'b1);
        checkOutput("w_err", m_err, 1'b0);
        step();
        manAck = '0;
        m_req  = 1'b0;
        checkOutput("w_done_sreq", s_req, 4'b0000);
        checkOutput("w_done_sel", sel, 4'b0000);
        checkOutput("w_done_ack", m_ack, 1'b0);

        // Unmapped read gets a one-cycle error response.
        applyStimulus(1'b0, 32'h0010_0000, 32'h0, 4'b0000, 1'b1, 1'b1);
        step();
        checkOutput("u_ack", m_ack, 1'b1);
        checkOutput("u_err", m_err, 1'b1);
        checkOutput("u_sreq", s_req, 4'b0000);
        checkOutput("u_sel", sel, 4'b0000);
        step();
        m_req = 1'b0;
        checkOutput("u_ack_end", m_ack, 1'b0);
        checkOutput("u_err_end", m_err, 1'b0);

        // Back-to-back zero-wait reads to slaves 0 then 1.
        autoAck = 4'b0011;
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'b0001, 1'b0, 1'b1);
        step();
        checkOutput("b2b_sel0", sel, 4'b0001);
        checkOutput("b2b_ack0", m_ack, 1'b1);
        step();
        checkOutput("b2b_gap_sel", sel, 4'b0000);
        checkOutput("b2b_gap_ack", m_ack, 1'b0);
        applyStimulus(1'b0, 32'h0001_0200, 32'h0, 4'b0010, 1'b0, 1'b1);
        step();
        checkOutput("b2b_sel1", sel, 4'b0010);
        checkOutput("b2b_ack1", m_ack, 1'b1);
        step();
        m_req   = 1'b0;
        autoAck = '0;
        checkOutput("b2b_end_sel", sel, 4'b0000);
        checkOutput("b2b_end_ack", m_ack, 1'b0);

        // Overlapping windows: slave 1 beats slave 3, stray ack[3] ignored.
        o_req  = 1'b1;
        o_addr = 32'h0001_0004;
        step();
        checkOutput("ovl_sreq", o_sreq, 4'b0010);
        checkOutput("ovl_sel", o_sel, 4'b0010);
        o_sack = 4'b1000;
        #1;
        checkOutput("ovl_stray", o_ack, 1'b0);
        step();
        o_sack = '0;
        checkOutput("ovl_hold", o_sreq, 4'b0010);
        o_sack = 4'b0010;
        #1;
        checkOutput("ovl_ack", o_ack, 1'b1);
        checkOutput("ovl_err", o_err, 1'b0);
        step();
        o_sack = '0;
        o_req  = 1'b0;
        checkOutput("ovl_done_sreq", o_sreq, 4'b0000);
        checkOutput("ovl_done_ack", o_ack, 1'b0);

        // Slave 3 never acknowledges.
`ifdef SIMPLE_ROUTER_TIMEOUT_EN
        applyStimulus(1'b0, 32'h0003_0000, 32'h0, 4'b0000, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 8; i++) begin
            checkOutput("to_sreq", s_req, 4'b1000);
            checkOutput("to_noack", m_ack, 1'b0);
            step();
        end
        checkOutput("to_sreq_clr", s_req, 4'b0000);
        checkOutput("to_ack", m_ack, 1'b1);
        checkOutput("to_err", m_err, 1'b1);
        step();
        m_req = 1'b0;
        checkOutput("to_end_ack", m_ack, 1'b0);
`else
        applyStimulus(1'b0, 32'h0003_0000, 32'h0, 4'b1000, 1'b0, 1'b1);
        step();
        repeat (1000) @(posedge clk);
        #1;
        checkOutput("nto_sreq", s_req, 4'b1000);
        checkOutput("nto_sel", sel, 4'b1000);
        checkOutput("nto_noack", m_ack, 1'b0);
        manAck = 4'b1000;
        #1;
        checkOutput("nto_ack", m_ack, 1'b1);
        step();
        manAck = '0;
        m_req  = 1'b0;
        checkOutput("nto_end_sreq", s_req, 4'b0000);
`endif

        // Reset two cycles into WAIT_ACK aborts the transaction silently.
        applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'b0001, 1'b0, 1'b0);
        step();
        step();
        checkOutput("ra_sreq_before", s_req, 4'b0001);
        #1;
        resetn = 1'b0;
        m_req  = 1'b0;
        #1;
        checkOutput("ra_sreq", s_req, 4'b0000);
        checkOutput("ra_sel", sel, 4'b0000);
        checkOutput("ra_ack", m_ack, 1'b0);
        step();
        checkOutput("ra_hold_sreq", s_req, 4'b0000);
        resetn  = 1'b1;
        autoAck = 4'b0001;
        applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'b0001, 1'b0, 1'b1);
        step();
        checkOutput("rr_sel", sel, 4'b0001);
        checkOutput("rr_ack", m_ack, 1'b1);
        checkOutput("rr_err", m_err, 1'b0);
        step();
        m_req   = 1'b0;
        autoAck = '0;
        checkOutput("rr_end_sel", sel, 4'b0000);

        // Everything predicted must have completed exactly once.
        step();
        step();
        checkOutput("sb_empty", sbq.size(), 0);
        checkOutput("ack_count", ackCount, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
